// File: rtl/ub_skew_read_sequencer_if.sv
// Bundle between the skewed read sequencer and its driver/buffer.
// Abort exists only when UB_SEQ_ABORT_EN is defined.
interface ub_skew_read_sequencer_if #(
  parameter int NUM_BANKS  = 16,
  parameter int BANK_DEPTH = 16
);
  localparam int ROW_BITS = $clog2(BANK_DEPTH);

  logic                               EN;
  logic                               Start;
  logic                               Stall;
  logic [ROW_BITS-1:0]                BaseAddress;
  logic [ROW_BITS:0]                  RowCount;
  logic [NUM_BANKS-1:0]               ReadValid;
  logic [NUM_BANKS-1:0][ROW_BITS-1:0] ReadAddress;
  logic [NUM_BANKS-1:0]               DataValid;
  logic                               Busy;
  logic                               Done;
`ifdef UB_SEQ_ABORT_EN
  logic                               Abort;

  modport master (
    output EN, Start, Stall, BaseAddress, RowCount, Abort,
    input  ReadValid, ReadAddress, DataValid, Busy, Done
  );
  modport slave (
    input  EN, Start, Stall, BaseAddress, RowCount, Abort,
    output ReadValid, ReadAddress, DataValid, Busy, Done
  );
`else
  modport master (
    output EN, Start, Stall, BaseAddress, RowCount,
    input  ReadValid, ReadAddress, DataValid, Busy, Done
  );
  modport slave (
    input  EN, Start, Stall, BaseAddress, RowCount,
    output ReadValid, ReadAddress, DataValid, Busy, Done
  );
`endif
endinterface

// File: rtl/ub_skew_read_sequencer.sv
// Diagonal (skewed) read sequencer over NUM_BANKS Unified Buffer banks.
// Optional Abort input enabled by defining UB_SEQ_ABORT_EN.
module ub_skew_read_sequencer #(
  parameter int NUM_BANKS    = 16,
  parameter int BANK_DEPTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input logic                     CLK,
  input logic                     ASYNC_RST,
  input logic                     SYNC_RST,
  ub_skew_read_sequencer_if.slave bus
);
  localparam int ROW_BITS = $clog2(BANK_DEPTH);
  localparam int T_BITS   = $clog2(BANK_DEPTH + NUM_BANKS + 1);
  localparam logic [ROW_BITS:0] ROWS_MAX = (ROW_BITS+1)'(BANK_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [NUM_BANKS-1:0][ROW_BITS-1:0] addr_t;

  state_t                     state, state_n;
  logic [T_BITS-1:0]          t, t_n;
  logic [ROW_BITS-1:0]        base, base_n;
  logic [ROW_BITS:0]          rows, rows_n;
  logic [NUM_BANKS-1:0]       rv, rv_n;
  addr_t                      ra, ra_n;
  logic [ROW_BITS:0]          clamped;
  logic [T_BITS-1:0]          last;
  logic                       go;
  logic [READ_LATENCY-1:0][NUM_BANKS-1:0] dv;
`ifdef UB_SEQ_ABORT_EN
  logic                       abort;
  assign abort = (state == RUN) && bus.Abort;
`endif

  assign clamped = (bus.RowCount > ROWS_MAX) ? ROWS_MAX : bus.RowCount;
  assign last = T_BITS'(rows) + T_BITS'(NUM_BANKS - 2);
  assign go   = bus.EN && !bus.Stall;

  // Bank k reads row (base + step - k) while its window is open.
  function automatic void issue(
    input  logic [T_BITS-1:0]    step,
    input  logic [ROW_BITS-1:0]  b,
    input  logic [ROW_BITS:0]    n,
    output logic [NUM_BANKS-1:0] v,
    output addr_t                a
  );
    logic [31:0] s;
    logic [31:0] kk;
    v = '0;
    a = '0;
    s = 32'(step);
    for (int k = 0; k < NUM_BANKS; k++) begin
      kk = 32'(k);
      if (s >= kk && s < kk + 32'(n)) begin
        v[k] = 1'b1;
        a[k] = ROW_BITS'((32'(b) + s - kk)
               % 32'(BANK_DEPTH));
      end
    end
  endfunction

  always_comb begin
    state_n = state;
    t_n     = t;
    base_n  = base;
    rows_n  = rows;
    rv_n    = '0;
    ra_n    = ra;
    unique case (state)
      IDLE: begin
        ra_n = '0;
        if (bus.EN && bus.Start) begin
          base_n = bus.BaseAddress;
          rows_n = clamped;
          t_n    = '0;
          if (clamped == '0) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
            issue('0, bus.BaseAddress, clamped,
                  rv_n, ra_n);
            t_n = T_BITS'(1);
          end
        end
      end
      RUN: begin
        // t is the next step to issue; held while stalled
        if (go) begin
          if (t > last) begin
            state_n = DONE;
            ra_n    = '0;
            t_n     = '0;
          end else begin
            issue(t, base, rows, rv_n, ra_n);
            t_n = t + T_BITS'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        ra_n    = '0;
      end
      default: begin
        state_n = IDLE;
        ra_n    = '0;
      end
    endcase
`ifdef UB_SEQ_ABORT_EN
    if (abort) begin
      state_n = IDLE;
      t_n     = '0;
      rv_n    = '0;
      ra_n    = '0;
    end
`endif
  end

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      state <= IDLE;
      t     <= '0;
      base  <= '0;
      rows  <= '0;
      rv    <= '0;
      ra    <= '0;
    end else if (SYNC_RST) begin
      state <= IDLE;
      t     <= '0;
      base  <= '0;
      rows  <= '0;
      rv    <= '0;
      ra    <= '0;
    end else begin
      state <= state_n;
      t     <= t_n;
      base  <= base_n;
      rows  <= rows_n;
      rv    <= rv_n;
      ra    <= ra_n;
    end
  end

  // Keeps shifting under Stall so in-flight reads still get flagged
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      dv <= '0;
    end else if (SYNC_RST) begin
      dv <= '0;
`ifdef UB_SEQ_ABORT_EN
    end else if (abort) begin
      dv <= '0;
`endif
    end else if (bus.EN) begin
      dv[0] <= rv;
      for (int i = 1; i < READ_LATENCY; i++) begin
        dv[i] <= dv[i-1];
      end
    end
  end

  assign bus.ReadValid   = rv;
  assign bus.ReadAddress = ra;
  assign bus.DataValid   = dv[READ_LATENCY-1];
  assign bus.Busy        = (state == RUN);
  assign bus.Done        = (state == DONE);

endmodule

// File: tb/tb_ub_skew_read_sequencer.sv
// Scoreboard bench for ub_skew_read_sequencer (16 banks, depth 16).
// Abort scenario included when UB_SEQ_ABORT_EN is defined.
module tb_ub_skew_read_sequencer;
  localparam int NB = 16;
  localparam int BD = 16;
  localparam int RB = 4;

  typedef struct packed {
    logic [NB-1:0]    rv;
    logic [NB*RB-1:0] ra;
    logic             busy;
    logic             done;
    logic             stall;
    logic             en;
    logic             start;
  } exp_t;

  logic CLK = 1'b0;
  logic ASYNC_RST;
  logic SYNC_RST;

  ub_skew_read_sequencer_if #(
    .NUM_BANKS(NB), .BANK_DEPTH(BD)
  ) bus ();

  ub_skew_read_sequencer #(
    .NUM_BANKS(NB), .BANK_DEPTH(BD),
    .READ_LATENCY(1)
  ) dut (
    .CLK(CLK),
    .ASYNC_RST(ASYNC_RST),
    .SYNC_RST(SYNC_RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int cap0[$];
  int cap15[$];
  int done_idx;
  int dones;
  logic [NB-1:0] prev_rv = '0;
  logic [NB-1:0] prev_dv = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int step,
                              input int base,
                              input int rows);
    exp_t e;
    e = '0;
    e.busy = 1'b1;
    e.en = 1'b1;
    for (int k = 0; k < NB; k++) begin
      if (step >= k && step < k + rows) begin
        e.rv[k] = 1'b1;
        e.ra[k*RB +: RB] = RB'((base + step - k) % BD);
      end
    end
    return e;
  endfunction

  task automatic plan(input int base, input int rows,
                      input int hold_at, input int hold_len,
                      input bit hold_en_low,
                      input int start_again,
                      input bit start_in_done);
    exp_t e;
    int r;
    int last;
    r = (rows > BD) ? BD : rows;
    if (r > 0) begin
      last = r + NB - 2;
      for (int s = 0; s <= last; s++) begin
        if (s == hold_at) begin
          for (int h = 0; h < hold_len; h++) begin
            e = mk(s - 1, base, r);
            e.rv = '0;
            e.stall = !hold_en_low;
            e.en = !hold_en_low;
            q.push_back(e);
          end
        end
        e = mk(s, base, r);
        e.start = (s == 0) || (s == start_again);
        q.push_back(e);
      end
    end
    e = '0;
    e.done = 1'b1;
    e.en = 1'b1;
    e.start = (r == 0);
    q.push_back(e);
    e = '0;
    e.en = 1'b1;
    e.start = start_in_done;
    q.push_back(e);
    e.start = 1'b0;
    q.push_back(e);
  endtask

  task automatic run_q(input string tag, input int limit);
    exp_t e;
    logic [NB-1:0] edv;
    int n;
    n = 0;
    dones = 0;
    done_idx = -1;
    cap0.delete();
    cap15.delete();
    while (q.size() > 0 && n < limit) begin
      e = q.pop_front();
      bus.Stall = e.stall;
      bus.EN = e.en;
      bus.Start = e.start;
      @(posedge CLK);
      #1;
      bus.Start = 1'b0;
      bus.Stall = 1'b0;
      bus.EN = 1'b1;
      edv = e.en ? prev_rv : prev_dv;
      chk({tag, "_rv"}, 64'(bus.ReadValid), 64'(e.rv));
      chk({tag, "_ra"}, 64'(bus.ReadAddress), e.ra);
      chk({tag, "_busy"}, 64'(bus.Busy), 64'(e.busy));
      chk({tag, "_done"}, 64'(bus.Done), 64'(e.done));
      chk({tag, "_dv"}, 64'(bus.DataValid), 64'(edv));
      prev_rv = e.rv;
      prev_dv = edv;
      cap0.push_back(int'(bus.ReadAddress[0]));
      cap15.push_back(int'(bus.ReadAddress[15]));
      if (bus.Done === 1'b1) begin
        if (dones == 0) done_idx = n;
        dones++;
      end
      n++;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rv"}, 64'(bus.ReadValid), 64'(0));
    chk({tag, "_ra"}, 64'(bus.ReadAddress), 64'(0));
    chk({tag, "_dv"}, 64'(bus.DataValid), 64'(0));
    chk({tag, "_busy"}, 64'(bus.Busy), 64'(0));
    chk({tag, "_done"}, 64'(bus.Done), 64'(0));
  endtask

  task automatic job(input string tag,
                     input int base, input int rows,
                     input int bus_rows);
    bus.BaseAddress = RB'(base);
    bus.RowCount = (RB+1)'(bus_rows);
    plan(base, rows, -1, 0, 1'b0, -1, 1'b0);
    run_q(tag, 1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ASYNC_RST = 1'b1;
    SYNC_RST = 1'b0;
    bus.EN = 1'b1;
    bus.Start = 1'b0;
    bus.Stall = 1'b0;
    bus.BaseAddress = '0;
    bus.RowCount = '0;
`ifdef UB_SEQ_ABORT_EN
    bus.Abort = 1'b0;
`endif
    #23;
    chk_quiet("reset");
    @(posedge CLK);
    #1;
    ASYNC_RST = 1'b0;

    // start on first edge after reset release
    job("b2r3", 2, 3, 3);
    chk("b2r3_b0s0", 64'(cap0[0]), 64'(2));
    chk("b2r3_b0s1", 64'(cap0[1]), 64'(3));
    chk("b2r3_b0s2", 64'(cap0[2]), 64'(4));
    chk("b2r3_b15s15", 64'(cap15[15]), 64'(2));
    chk("b2r3_b15s16", 64'(cap15[16]), 64'(3));
    chk("b2r3_b15s17", 64'(cap15[17]), 64'(4));
    chk("b2r3_doneidx", 64'(done_idx), 64'(18));
    chk("b2r3_dones", 64'(dones), 64'(1));

    job("wrap", 14, 4, 4);
    chk("wrap_b0s0", 64'(cap0[0]), 64'(14));
    chk("wrap_b0s1", 64'(cap0[1]), 64'(15));
    chk("wrap_b0s2", 64'(cap0[2]), 64'(0));
    chk("wrap_b0s3", 64'(cap0[3]), 64'(1));
    chk("wrap_dones", 64'(dones), 64'(1));

    job("rows0", 6, 0, 0);
    chk("rows0_doneidx", 64'(done_idx), 64'(0));
    chk("rows0_dones", 64'(dones), 64'(1));

    job("rows20", 1, 20, 20);
    chk("rows20_doneidx", 64'(done_idx), 64'(31));
    chk("rows20_dones", 64'(dones), 64'(1));

    bus.BaseAddress = 4'd9;
    bus.RowCount = 5'd5;
    plan(9, 5, 5, 3, 1'b0, -1, 1'b0);
    run_q("stall", 1000);
    chk("stall_doneidx", 64'(done_idx), 64'(23));
    chk("stall_dones", 64'(dones), 64'(1));

    // EN low gap plus Start ignored in RUN and DONE
    bus.BaseAddress = 4'd0;
    bus.RowCount = 5'd2;
    plan(0, 2, 3, 2, 1'b1, 4, 1'b1);
    run_q("enlow", 1000);
    chk("enlow_doneidx", 64'(done_idx), 64'(19));
    chk("enlow_dones", 64'(dones), 64'(1));

    bus.BaseAddress = 4'd5;
    bus.RowCount = 5'd6;
    plan(5, 6, -1, 0, 1'b0, -1, 1'b0);
    run_q("arst", 8);
    q.delete();
    ASYNC_RST = 1'b1;
    #1;
    chk_quiet("arst_now");
    @(posedge CLK);
    #1;
    chk_quiet("arst_hold");
    ASYNC_RST = 1'b0;
    prev_rv = '0;
    prev_dv = '0;
    job("arst_new", 3, 2, 2);
    chk("arst_new_dones", 64'(dones), 64'(1));

    bus.BaseAddress = 4'd7;
    bus.RowCount = 5'd4;
    plan(7, 4, -1, 0, 1'b0, -1, 1'b0);
    run_q("srst", 10);
    q.delete();
    SYNC_RST = 1'b1;
    @(posedge CLK);
    #1;
    SYNC_RST = 1'b0;
    chk_quiet("srst_now");
    @(posedge CLK);
    #1;
    chk_quiet("srst_after");
    prev_rv = '0;
    prev_dv = '0;

`ifdef UB_SEQ_ABORT_EN
    bus.BaseAddress = 4'd3;
    bus.RowCount = 5'd5;
    plan(3, 5, -1, 0, 1'b0, -1, 1'b0);
    run_q("abort", 5);
    q.delete();
    bus.Abort = 1'b1;
    @(posedge CLK);
    #1;
    bus.Abort = 1'b0;
    chk_quiet("abort_now");
    @(posedge CLK);
    #1;
    chk_quiet("abort_after");
    prev_rv = '0;
    prev_dv = '0;
    job("abort_new", 1, 1, 1);
    chk("abort_new_dones", 64'(dones), 64'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/ub_skew_read_sequencer.md
UB_SKEW_READ_SEQUENCER -- requirements
Module: ub_skew_read_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 16, number of Unified Buffer banks sequenced.
REQ-002 The block SHALL have parameter BANK_DEPTH, default 16, rows per bank; ROW_BITS = $clog2(BANK_DEPTH).
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, cycles from ReadValid to buffer read data.
REQ-004 The block SHALL have one clock, CLK, an input of width 1; all state updates on its rising edge.
REQ-005 The block SHALL have ASYNC_RST, an input of width 1; reset is asynchronous and active-high.
REQ-006 The block SHALL have SYNC_RST, an input of width 1; synchronous clear, active-high.
REQ-007 The block SHALL have EN, an input of width 1; global enable, freezes the block when low.
REQ-008 The block SHALL have Start, an input of width 1; request to begin a skewed read job.
REQ-009 The block SHALL have BaseAddress, an input of width ROW_BITS; first row read by bank 0.
REQ-010 The block SHALL have RowCount, an input of width ROW_BITS+1; rows per bank, 0..BANK_DEPTH.
REQ-011 The block SHALL have Stall, an input of width 1; downstream backpressure.
REQ-012 The block SHALL have ReadValid, an output of NUM_BANKS x 1; per-bank read strobe to the buffer read port.
REQ-013 The block SHALL have ReadAddress, an output of NUM_BANKS x ROW_BITS; per-bank read row.
REQ-014 The block SHALL have DataValid, an output of NUM_BANKS x 1; ReadValid delayed READ_LATENCY cycles, marking valid read data.
REQ-015 The block SHALL have Busy, an output of width 1, high in RUN; and Done, an output of width 1, one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE; Start sampled high in IDLE with EN high SHALL move to RUN and latch BaseAddress and RowCount.
REQ-017 A latched RowCount greater than BANK_DEPTH SHALL be clamped to BANK_DEPTH.
REQ-018 A latched RowCount of 0 SHALL go IDLE->DONE directly, asserting no ReadValid.
REQ-019 In RUN a step counter t SHALL count 0..RowCount+NUM_BANKS-2, advancing once per cycle when EN is high and Stall is low.
REQ-020 At step t, ReadValid[k] SHALL be 1 iff k <= t < k+RowCount, and ReadAddress[k] = (BaseAddress + t - k) mod BANK_DEPTH, wrapping at row BANK_DEPTH-1 -> 0.
REQ-021 ReadValid and ReadAddress SHALL be registered; step 0 SHALL appear the cycle after the edge that samples Start.
REQ-022 While Stall or !EN, all ReadValid SHALL be 0 and t and ReadAddress SHALL hold; the step resumes unchanged when released.
REQ-023 After the last step issues, the FSM SHALL enter DONE; Done SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 Start in RUN or DONE SHALL be ignored, with no queuing.
REQ-025 The DataValid pipeline SHALL keep shifting under Stall, so in-flight data is still flagged.
REQ-026 ReadAddress of banks with ReadValid 0 SHALL be 0.

Reset
REQ-027 ASYNC_RST high SHALL immediately force IDLE, t=0, and all ReadValid, ReadAddress, DataValid, Busy and Done to 0.
REQ-028 SYNC_RST high at a rising edge SHALL produce the same state as ASYNC_RST, including mid-RUN, with no Done pulse.
REQ-029 Start sampled on the first edge after reset release SHALL be honoured.

Configuration
REQ-030 With macro UB_SEQ_ABORT_EN defined, the block SHALL add input Abort (width 1); Abort high in RUN SHALL return to IDLE next edge, clear ReadValid, flush DataValid and suppress Done.
REQ-031 Without UB_SEQ_ABORT_EN, the Abort port and its logic SHALL be absent.

Verification
REQ-032 Verification SHALL cover: Start, Base=2, RowCount=3 -> bank0 reads 2,3,4 at steps 0-2; bank15 reads 2,3,4 at steps 15-17; Done pulses once after step 17.
REQ-033 Verification SHALL cover: Base=14, RowCount=4 -> bank0 addresses 14,15,0,1 (wrap).
REQ-034 Verification SHALL cover: RowCount=0 -> no ReadValid, Done one cycle after Start; RowCount=20 -> behaves as 16.
REQ-035 Verification SHALL cover: Stall high for 3 cycles at step 5 -> ReadValid all 0 for 3 cycles, then step 5 reissues identically, and Done is delayed by 3 cycles.
REQ-036 Verification SHALL cover: ASYNC_RST pulse mid-RUN at step 7 -> all outputs 0 immediately with no Done, and a new Start then runs normally.
REQ-037 Verification SHALL cover, with UB_SEQ_ABORT_EN defined: Abort at step 4 -> IDLE next edge, DataValid cleared and no Done.
